// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size/state encodings, schedule depth and GF(2^8) helpers.
// The ZERO state only exists when KEYEXP_ZEROIZE_EN is defined.
package aes_pkg;

  typedef enum logic [1:0] {
    KS_128  = 2'b00,
    KS_192  = 2'b01,
    KS_256  = 2'b10,
    KS_RSVD = 2'b11
  } key_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND
`ifdef KEYEXP_ZEROIZE_EN
    , ST_ZERO
`endif
  } ks_state_e;

  localparam int MAX_WORDS = 60;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rotWord(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [3:0] nk_of(input key_size_e ks);
    case (ks)
      KS_192:  return 4'd6;
      KS_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_size_e ks);
    case (ks)
      KS_192:  return 4'd12;
      KS_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^127 by repeated square-and-multiply, then one square).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = x;
    for (int k = 0; k < 6; k++) t = gf_mul(gf_mul(t, t), x);
    return gf_mul(t, t);
  endfunction

endpackage

// File: rtl/key_schedule_seq_if.sv
// Key-schedule control/read bus. start/keySize/initialKey are sampled on a clock edge
// only while busy=0; done and keyErr are single-cycle pulses; rdKey follows rdRound one cycle later.
interface key_schedule_seq_if #(parameter int MAX_NK = 8);
  import aes_pkg::*;

  logic                  start;
  logic [1:0]            keySize;
  logic [32*MAX_NK-1:0]  initialKey;
  logic                  busy;
  logic                  done;
  logic                  keyErr;
  logic                  keysValid;
  logic [3:0]            rdRound;
  logic [127:0]          rdKey;
  ks_state_e             dbg_state;
`ifdef KEYEXP_ZEROIZE_EN
  logic                  zeroize;
`endif

  modport master (
    output start, keySize, initialKey, rdRound,
`ifdef KEYEXP_ZEROIZE_EN
    output zeroize,
`endif
    input  busy, done, keyErr, keysValid, rdKey, dbg_state
  );

  modport slave (
    input  start, keySize, initialKey, rdRound,
`ifdef KEYEXP_ZEROIZE_EN
    input  zeroize,
`endif
    output busy, done, keyErr, keysValid, rdKey, dbg_state
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(a);
    s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/key_schedule_seq.sv
// Iterative AES-128/192/256 key schedule: one word per clock into a word store, registered round-key read.
// Optional KEYEXP_ZEROIZE_EN adds the zeroize input and a ZERO state that wipes the store.
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
)(
  input  logic               clk,
  input  logic               rst_n,
  key_schedule_seq_if.slave  bus
);

  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = $clog2(MAX_NK);
`ifdef KEYEXP_ZEROIZE_EN
  localparam int ZW    = $clog2(DEPTH / 4);
  logic [ZW-1:0]  zc_q;
`endif

  ks_state_e      state;
  logic [3:0]     nk_q;
  logic [3:0]     nr_q;
  logic [IW-1:0]  i_q;
  logic [IW-1:0]  last_q;
  logic [PW-1:0]  phase_q;
  logic [7:0]     rcon_q;
  logic           busy_q;
  logic           done_q;
  logic           key_err_q;
  logic           keys_valid_q;
  logic [127:0]   rd_key_q;
  logic [31:0]    w [DEPTH];

  key_size_e      ks_in;
  logic [31:0]    prev_word;
  logic [31:0]    back_word;
  logic [31:0]    sub_in;
  logic [31:0]    sub_out;
  logic [31:0]    temp;
  logic [31:0]    new_word;
  logic [IW-1:0]  rd_base;

  assign ks_in = key_size_e'(bus.keySize);

  always_comb begin
    prev_word = w[i_q - IW'(1)];
    back_word = w[i_q - IW'(nk_q)];
    sub_in    = (phase_q == '0) ? rotWord(prev_word) : prev_word;
    if (phase_q == '0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && phase_q == PW'(4))
      temp = sub_out;
    else
      temp = prev_word;
    new_word = back_word ^ temp;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*g +: 8]),
      .s (sub_out[8*g +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef KEYEXP_ZEROIZE_EN
      state        <= ST_ZERO;
      zc_q         <= '0;
`else
      state        <= ST_IDLE;
`endif
      nk_q         <= 4'd4;
      nr_q         <= 4'd10;
      i_q          <= '0;
      last_q       <= '0;
      phase_q      <= '0;
      rcon_q       <= 8'h01;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      key_err_q    <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      key_err_q <= 1'b0;
`ifdef KEYEXP_ZEROIZE_EN
      if (bus.zeroize) begin
        state        <= ST_ZERO;
        zc_q         <= '0;
        busy_q       <= 1'b0;
        keys_valid_q <= 1'b0;
      end else
`endif
      begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              if (ks_in != KS_RSVD) begin
                nk_q         <= nk_of(ks_in);
                nr_q         <= nr_of(ks_in);
                last_q       <= IW'(4 * (int'(nr_of(ks_in)) + 1) - 1);
                keys_valid_q <= 1'b0;
                busy_q       <= 1'b1;
                state        <= ST_LOAD;
              end else begin
                key_err_q    <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            i_q     <= IW'(nk_q);
            phase_q <= '0;
            rcon_q  <= 8'h01;
            state   <= ST_EXPAND;
          end
          ST_EXPAND: begin
            // phase_q tracks i mod nk without a divider
            if (phase_q == '0) rcon_q <= xtime(rcon_q);
            phase_q <= (phase_q == PW'(nk_q - 4'd1)) ? '0 : phase_q + PW'(1);
            i_q     <= i_q + IW'(1);
            if (i_q == last_q) begin
              state        <= ST_IDLE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              keys_valid_q <= 1'b1;
            end
          end
`ifdef KEYEXP_ZEROIZE_EN
          ST_ZERO: begin
            zc_q <= zc_q + ZW'(1);
            if (zc_q == ZW'(DEPTH / 4 - 1)) state <= ST_IDLE;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Word store: deliberately unreset; cleared only by the ZERO state when present.
  always_ff @(posedge clk) begin
    case (state)
      ST_LOAD: begin
        for (int k = 0; k < MAX_NK; k++)
          if (k < int'(nk_q)) w[k] <= bus.initialKey[32*(MAX_NK-k)-1 -: 32];
      end
      ST_EXPAND: w[i_q] <= new_word;
`ifdef KEYEXP_ZEROIZE_EN
      ST_ZERO: begin
        for (int j = 0; j < 4; j++) w[{zc_q, 2'(j)}] <= 32'h0;
      end
`endif
      default: ;
    endcase
  end

  assign rd_base = IW'({bus.rdRound, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key_q <= '0;
    end else if (keys_valid_q && bus.rdRound <= nr_q) begin
      rd_key_q <= {w[rd_base], w[rd_base + IW'(1)], w[rd_base + IW'(2)], w[rd_base + IW'(3)]};
    end else begin
      rd_key_q <= '0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.keyErr    = key_err_q;
  assign bus.keysValid = keys_valid_q;
  assign bus.rdKey     = rd_key_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: FIPS-197 vectors, randomized keys against a
// behavioural key-expansion model, key-size error, ignored start, mid-run reset, optional zeroize.
module tb_key_schedule_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_schedule_seq_if #(.MAX_NK(8)) bus();

  key_schedule_seq #(.MAX_NK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]   sbox_t [256];
  logic [31:0]  mw [60];
  logic [127:0] exp_q [$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[a] = s;
    end
  endtask

  function automatic logic [31:0] ref_subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic model_expand(input int ks, input logic [255:0] key, output int nr);
    int nk;
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2 * ks;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t = ref_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = ref_mul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = ref_subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_run(input logic [1:0] ks, input logic [255:0] key);
    @(negedge clk);
    bus.start = 1'b1;
    bus.keySize = ks;
    bus.initialKey = key;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Caller sits in cycle 1 after the sampling edge; returns cycle of done (or 200 on timeout).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic read_round(input int r, output logic [127:0] val);
    bus.rdRound = 4'(r);
    @(negedge clk);
    val = bus.rdKey;
  endtask

  task automatic check_schedule(input int nr, input string tag);
    logic [127:0] got;
    logic [127:0] exp;
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) exp_q.push_back({mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
      else         exp_q.push_back(128'h0);
    end
    for (int r = 0; r < 16; r++) begin
      read_round(r, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s round %0d: got %h expected %h", tag, r, got, exp);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.keyErr !== 1'b0) begin n_fail++; $display("FAIL reset_keyerr: got %b expected 0", bus.keyErr); end
    n_checks++; if (bus.keysValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.keysValid); end
    n_checks++; if (bus.rdKey !== 128'h0) begin n_fail++; $display("FAIL reset_rdkey: got %h expected 0", bus.rdKey); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_vector(input logic [1:0] ks, input logic [255:0] key, input int exp_cyc,
                             input logic [127:0] last_key, input string tag);
    int cyc;
    int nr;
    logic [127:0] got;
    model_expand(int'(ks), key, nr);
    start_run(ks, key);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_t1: got %b expected 1", tag, bus.busy); end
    wait_done(cyc);
    n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, cyc, exp_cyc); end
    n_checks++; if (bus.keysValid !== 1'b1) begin n_fail++; $display("FAIL %s keysvalid: got %b expected 1", tag, bus.keysValid); end
    read_round(nr, got);
    n_checks++; if (got !== last_key) begin n_fail++; $display("FAIL %s last_round: got %h expected %h", tag, got, last_key); end
    check_schedule(nr, tag);
  endtask

  task automatic test_random();
    int ks, cyc, nr;
    logic [255:0] key;
    logic [127:0] got;
    for (int it = 0; it < 6; it++) begin
      ks = $urandom_range(0, 2);
      key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      model_expand(ks, key, nr);
      start_run(2'(ks), key);
      cyc = 1;
      bus.rdRound = 4'($urandom_range(0, 10));
      while (bus.done !== 1'b1 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (cyc == 10) begin
          n_checks++;
          if (bus.rdKey !== 128'h0) begin n_fail++; $display("FAIL rand%0d read_during_expand: got %h expected 0", it, bus.rdKey); end
        end
      end
      n_checks++;
      if (cyc !== 4 * (nr + 1) - (4 + 2 * ks) + 2) begin
        n_fail++; $display("FAIL rand%0d done_cycle: got %0d expected %0d", it, cyc, 4 * (nr + 1) - (4 + 2 * ks) + 2);
      end
      check_schedule(nr, $sformatf("rand%0d", it));
      read_round(15, got);
      n_checks++; if (got !== 128'h0) begin n_fail++; $display("FAIL rand%0d round15: got %h expected 0", it, got); end
    end
  endtask

  task automatic test_key_err();
    int cyc, nr;
    logic [255:0] key;
    key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    model_expand(0, key, nr);
    start_run(2'b00, key);
    wait_done(cyc);
    start_run(2'b11, ~key);
    n_checks++; if (bus.keyErr !== 1'b1) begin n_fail++; $display("FAIL keyerr_pulse: got %b expected 1", bus.keyErr); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL keyerr_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.keyErr !== 1'b0) begin n_fail++; $display("FAIL keyerr_width: got %b expected 0", bus.keyErr); end
    n_checks++; if (bus.keysValid !== 1'b1) begin n_fail++; $display("FAIL keyerr_valid: got %b expected 1", bus.keysValid); end
    check_schedule(nr, "keyerr_keep");
  endtask

  task automatic test_back_to_back_ignore();
    int cyc, nr;
    logic [255:0] key;
    key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    model_expand(0, key, nr);
    start_run(2'b00, key);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (cyc == 20) begin
        bus.start = 1'b1; bus.keySize = 2'b10;
        bus.initialKey = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end
    n_checks++; if (cyc !== 42) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d expected 42", cyc); end
    check_schedule(nr, "ignore");
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen_done;
    logic [255:0] key;
    key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    start_run(2'b10, key);
    for (cyc = 1; cyc < 30; cyc++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.keysValid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", bus.keysValid); end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses expected 0", seen_done); end
    n_checks++; if (bus.keysValid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid_after: got %b expected 0", bus.keysValid); end
  endtask

`ifdef KEYEXP_ZEROIZE_EN
  task automatic test_zeroize();
    int cyc, nr;
    logic [255:0] key;
    logic [127:0] got;
    key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    model_expand(2, key, nr);
    start_run(2'b10, key);
    wait_done(cyc);
    @(negedge clk);
    bus.zeroize = 1'b1;
    @(negedge clk);
    bus.zeroize = 1'b0;
    for (int k = 0; k < 15; k++) begin
      n_checks++;
      if (bus.busy !== 1'b0 || bus.keysValid !== 1'b0) begin
        n_fail++; $display("FAIL zeroize_cycle%0d: busy %b valid %b expected 0 0", k, bus.busy, bus.keysValid);
      end
      @(negedge clk);
    end
    force dut.keys_valid_q = 1'b1;
    for (int r = 0; r <= nr; r++) begin
      read_round(r, got);
      n_checks++; if (got !== 128'h0) begin n_fail++; $display("FAIL zeroize_round%0d: got %h expected 0", r, got); end
    end
    release dut.keys_valid_q;
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.keySize = 2'b00;
    bus.initialKey = '0;
    bus.rdRound = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
    bus.zeroize = 1'b0;
`endif
    build_sbox();
    test_reset();
    test_vector(2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 42,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128");
    test_vector(2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 48,
                128'he98ba06f448c773c8ecc720401002202, "aes192");
    test_vector(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 54,
                128'hfe4890d1e6188d0b046df344706c631e, "aes256");
    test_random();
    test_key_err();
    test_back_to_back_ignore();
    test_reset_mid();
    repeat (20) @(negedge clk);
`ifdef KEYEXP_ZEROIZE_EN
    test_zeroize();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
